// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the byte-stream to RAM word loader.
// Holds the FSM state encoding, default address width and RAM byte-lane codes.
package ram_loader_pkg;

  localparam int LOADER_ADDR_W = 10;
  localparam int LOADER_DEPTH  = 1 << LOADER_ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } loader_state_e;

  localparam logic [1:0] BE_LOW  = 2'b01;
  localparam logic [1:0] BE_BOTH = 2'b11;

endpackage

// File: rtl/ram_stream_loader_if.sv
// Byte stream (valid/ready) plus RAM Avalon write port seen by the loader.
// master = loader side (consumes stream, drives RAM); slave = environment side.
interface ram_stream_loader_if
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = LOADER_ADDR_W
) ();

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;

  logic [ADDR_W-1:0] address;
  logic [1:0]        byteenable;
  logic              chipselect;
  logic              write;
  logic [15:0]       writedata;
  logic              clken;

  modport master (
    input  in_data, in_valid, in_last,
    output in_ready,
    output address, byteenable, chipselect, write, writedata, clken
  );

  modport slave (
    output in_data, in_valid, in_last,
    input  in_ready,
    input  address, byteenable, chipselect, write, writedata, clken
  );

endinterface

// File: rtl/ram_stream_loader.sv
// Packs an 8-bit stream little-endian into 16-bit words and writes them to RAM
// from a programmed base address, tracking word count and dropped-byte overflow.
module ram_stream_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = LOADER_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_address,
  input  logic [ADDR_W:0]     len_words,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     word_count,
  output logic                overflow,
  ram_stream_loader_if.master bus
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   limit_q;
  logic [7:0]        low_q;
  logic              accept;
  logic              room;

  assign bus.in_ready = (state_q == LOW) || (state_q == HIGH);
  assign bus.clken    = 1'b1;
  assign accept       = bus.in_valid && bus.in_ready;
  assign room         = (word_count != limit_q);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)  state_d = LOW;
      LOW:     if (accept) state_d = bus.in_last ? DONE : HIGH;
      HIGH:    if (accept) state_d = bus.in_last ? DONE : LOW;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: only control/status and captured bytes live here, so resetting them all is cheap and keeps outputs defined.
      base_q         <= '0;
      limit_q        <= '0;
      low_q          <= '0;
      word_count     <= '0;
      overflow       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.write      <= 1'b0;
      bus.chipselect <= 1'b0;
      bus.address    <= '0;
      bus.byteenable <= '0;
      bus.writedata  <= '0;
    end else begin
      bus.write      <= 1'b0;
      bus.chipselect <= 1'b0;
      busy           <= (state_d != IDLE);
      done           <= (state_q == DONE);

      if (state_q == IDLE && start) begin
        base_q     <= base_address;
        limit_q    <= (len_words == '0) ? DEPTH : len_words;
        word_count <= '0;
        overflow   <= 1'b0;
      end

      if (accept) begin
        if (!room) begin
          // Limit reached: drain the byte so the frame can still reach in_last.
          overflow <= 1'b1;
        end else if (state_q == LOW) begin
          low_q <= bus.in_data;
          if (bus.in_last) begin
            bus.write      <= 1'b1;
            bus.chipselect <= 1'b1;
            bus.address    <= base_q + word_count[ADDR_W-1:0];
            bus.byteenable <= BE_LOW;
            bus.writedata  <= {8'h00, bus.in_data};
            word_count     <= word_count + (ADDR_W+1)'(1);
          end
        end else begin
          bus.write      <= 1'b1;
          bus.chipselect <= 1'b1;
          bus.address    <= base_q + word_count[ADDR_W-1:0];
          bus.byteenable <= BE_BOTH;
          bus.writedata  <= {bus.in_data, low_q};
          word_count     <= word_count + (ADDR_W+1)'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_stream_loader.sv
// Scoreboard bench for ram_stream_loader: a byte-level model queues the expected
// RAM writes, a negedge monitor pops and compares each write the DUT issues.
module tb_ram_stream_loader;
  import ram_loader_pkg::*;

  localparam int AW = LOADER_ADDR_W;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    be;
    logic [15:0]   data;
    logic [AW:0]   wc;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_address;
  logic [AW:0]   len_words;
  logic          busy;
  logic          done;
  logic [AW:0]   word_count;
  logic          overflow;

  ram_stream_loader_if #(.ADDR_W(AW)) bus ();

  ram_stream_loader #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_address (base_address),
    .len_words    (len_words),
    .busy         (busy),
    .done         (done),
    .word_count   (word_count),
    .overflow     (overflow),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  wr_t exp_q[$];
  wr_t mon_obs, mon_exp;
  int  checks   = 0;
  int  failures = 0;

  // Write monitor: every write pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.write === 1'b1 || bus.chipselect === 1'b1) begin
      mon_obs = {bus.address, bus.byteenable, bus.writedata, word_count};
      checks++;
      if (bus.write !== bus.chipselect) begin
        failures++;
        $display("FAIL write_strobe: write=%b chipselect=%b, required both equal", bus.write, bus.chipselect);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: addr=%h be=%b data=%h wc=%0d, required no write",
                 mon_obs.addr, mon_obs.be, mon_obs.data, mon_obs.wc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_obs !== mon_exp) begin
          failures++;
          $display("FAIL write_content: got addr=%h be=%b data=%h wc=%0d, required addr=%h be=%b data=%h wc=%0d",
                   mon_obs.addr, mon_obs.be, mon_obs.data, mon_obs.wc,
                   mon_exp.addr, mon_exp.be, mon_exp.data, mon_exp.wc);
        end
      end
    end
  end

  // Byte-level model: pushes expected writes, returns final word count and overflow.
  task automatic model(input logic [AW-1:0] base, input logic [AW:0] len,
                       input logic [7:0] b[8], input int n,
                       output int wc, output bit ov);
    int         eff;
    logic [7:0] lo;
    wr_t        e;
    eff = (len == 0) ? (1 << AW) : int'(len);
    wc  = 0;
    ov  = 1'b0;
    lo  = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (wc >= eff) begin
        ov = 1'b1;
      end else if (i % 2 == 0) begin
        lo = b[i];
        if (i == n - 1) begin
          e.addr = base + AW'(wc);
          e.be   = 2'b01;
          e.data = {8'h00, b[i]};
          e.wc   = (AW+1)'(wc + 1);
          exp_q.push_back(e);
          wc++;
        end
      end else begin
        e.addr = base + AW'(wc);
        e.be   = 2'b11;
        e.data = {b[i], lo};
        e.wc   = (AW+1)'(wc + 1);
        exp_q.push_back(e);
        wc++;
      end
    end
  endtask

  // Full load: start, stream n bytes back-to-back (last on byte n-1), check completion timing.
  // With inject set, a stray start and an unqualified in_last are driven after the first byte.
  task automatic do_load(input string name, input logic [AW-1:0] base, input logic [AW:0] len,
                         input logic [7:0] b[8], input int n, input bit inject);
    int wc;
    bit ov;
    model(base, len, b, n, wc, ov);

    @(negedge clk);
    start        = 1'b1;
    base_address = base;
    len_words    = len;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy_after_start: got %b, required 1", name, busy);
    end

    for (int i = 0; i < n; i++) begin
      bus.in_data  = b[i];
      bus.in_valid = 1'b1;
      bus.in_last  = (i == n - 1);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s_in_ready_byte%0d: got %b, required 1", name, i, bus.in_ready);
        for (int w = 0; w < 20 && bus.in_ready !== 1'b1; w++) @(negedge clk);
      end
      @(posedge clk);
      @(negedge clk);
      if (inject && i == 0) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b1;
        start        = 1'b1;
        base_address = ~base;
        len_words    = (AW+1)'(1);
        @(negedge clk);
        start       = 1'b0;
        bus.in_last = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    // Cycle N+1: DONE state, still busy, no done yet.
    checks++;
    if ({busy, done, bus.in_ready} !== 3'b100) begin
      failures++;
      $display("FAIL %s_n_plus_1: got busy/done/in_ready=%b, required 100", name, {busy, done, bus.in_ready});
    end
    @(negedge clk);
    // Cycle N+2: done pulse, idle, results visible.
    checks++;
    if ({busy, done} !== 2'b01) begin
      failures++;
      $display("FAIL %s_n_plus_2: got busy/done=%b, required 01", name, {busy, done});
    end
    checks++;
    if (word_count !== (AW+1)'(wc)) begin
      failures++;
      $display("FAIL %s_word_count: got %0d, required %0d", name, word_count, wc);
    end
    checks++;
    if (overflow !== ov) begin
      failures++;
      $display("FAIL %s_overflow: got %b, required %b", name, overflow, ov);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_writes: %0d outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_width: got %b, required 0", name, done);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    start        = 1'b0;
    base_address = '0;
    len_words    = '0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.write, bus.chipselect, busy, done, overflow, bus.address,
         bus.byteenable, bus.writedata, word_count, bus.clken} !== {6'b0, 10'h0, 2'b0, 16'h0, 11'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_values: got ready=%b wr=%b cs=%b busy=%b done=%b ovf=%b addr=%h be=%b data=%h wc=%0d clken=%b, required all 0 with clken=1",
               bus.in_ready, bus.write, bus.chipselect, busy, done, overflow, bus.address,
               bus.byteenable, bus.writedata, word_count, bus.clken);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] b[8] = '{0: 8'h11, 1: 8'h22, 2: 8'h33, 3: 8'h44, default: 8'h00};
    do_load("basic", 10'h010, 11'd4, b, 4, 1'b0);
  endtask

  task automatic test_odd_tail();
    logic [7:0] b[8] = '{0: 8'hAA, 1: 8'hBB, 2: 8'hCC, default: 8'h00};
    do_load("odd_tail", 10'h020, 11'd8, b, 3, 1'b0);
  endtask

  task automatic test_wrap();
    logic [7:0] b[8] = '{0: 8'h01, 1: 8'h02, 2: 8'h03, 3: 8'h04, default: 8'h00};
    do_load("wrap", 10'h3FF, 11'd2, b, 4, 1'b0);
  endtask

  task automatic test_overflow();
    logic [7:0] b[8] = '{0: 8'h5A, 1: 8'hA5, 2: 8'hC3, 3: 8'hD4, default: 8'h00};
    do_load("overflow", 10'h100, 11'd1, b, 4, 1'b0);
  endtask

  task automatic test_len_zero();
    logic [7:0] b[8] = '{0: 8'hE1, 1: 8'hE2, 2: 8'hE3, 3: 8'hE4, 4: 8'hE5, default: 8'h00};
    do_load("len_zero", 10'h3FE, 11'd0, b, 5, 1'b0);
  endtask

  task automatic test_reset_midload();
    logic [7:0] b[8] = '{0: 8'h99, 1: 8'hAA, default: 8'h00};
    @(negedge clk);
    start        = 1'b1;
    base_address = 10'h050;
    len_words    = 11'd4;
    @(negedge clk);
    start        = 1'b0;
    bus.in_data  = 8'h77;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    @(negedge clk);
    bus.in_data = 8'h88;
    reset       = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.in_ready, bus.write, bus.chipselect, busy, done, overflow, bus.address,
         bus.byteenable, bus.writedata, word_count} !== '0) begin
      failures++;
      $display("FAIL midload_reset_values: got ready=%b wr=%b cs=%b busy=%b done=%b ovf=%b addr=%h be=%b data=%h wc=%0d, required all 0",
               bus.in_ready, bus.write, bus.chipselect, busy, done, overflow, bus.address,
               bus.byteenable, bus.writedata, word_count);
    end
    reset = 1'b0;
    do_load("after_reset", 10'h050, 11'd4, b, 2, 1'b0);
  endtask

  task automatic test_start_while_busy();
    logic [7:0] b[8] = '{0: 8'h10, 1: 8'h20, 2: 8'h30, 3: 8'h40, default: 8'h00};
    do_load("start_busy", 10'h200, 11'd3, b, 4, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1[8] = '{0: 8'h0F, 1: 8'hF0, default: 8'h00};
    logic [7:0] b2[8] = '{0: 8'h3C, 1: 8'hC3, 2: 8'h66, default: 8'h00};
    do_load("b2b_first", 10'h123, 11'd5, b1, 2, 1'b0);
    do_load("b2b_second", 10'h124, 11'd5, b2, 3, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_odd_tail();
    test_wrap();
    test_overflow();
    test_len_zero();
    test_reset_midload();
    test_start_while_busy();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_stream_loader.md
# ram_stream_loader

Upstream feeder for the 16-bit × 1024-word single-port on-chip RAM. Accepts an 8-bit valid/ready byte stream (e.g. from a UART or host bridge) and packs byte pairs little-endian into 16-bit words. Each word is written into the RAM's Avalon slave port as a single-cycle write with byteenable, starting at a programmed base address. Reports completion, word count and overflow to a control/status register block.

## Interface
- ADDR_W, 10, RAM word-address width; DEPTH = 2**ADDR_W words
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a load (ignored unless idle)
- base_address  in  ADDR_W  first word address, sampled on start
- len_words  in  ADDR_W+1  word limit, sampled on start; 0 means DEPTH
- in_data  in  8  stream byte
- in_valid  in  1  byte present
- in_last  in  1  final byte of frame, qualified by in_valid
- in_ready  out  1  byte accepted when in_valid & in_ready
- address  out  ADDR_W  RAM word address
- byteenable  out  2  RAM byte lanes
- chipselect  out  1  RAM select
- write  out  1  RAM write strobe
- writedata  out  16  RAM write data
- clken  out  1  RAM clock enable, constant 1
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at end of load
- word_count  out  ADDR_W+1  words written in current/last load
- overflow  out  1  sticky: bytes dropped past len_words

## Operation
- FSM states: IDLE, LOW (expect low byte), HIGH (expect high byte), DONE.
- IDLE: in_ready=0. On start, latch base_address and len_words, clear word_count and overflow, then go to LOW.
- LOW: in_ready=1. An accepted byte goes to writedata[7:0].
  - in_last=1: issue a write with byteenable=01, then go to DONE.
  - Otherwise go to HIGH.
- HIGH: in_ready=1. An accepted byte goes to writedata[15:8] and a write is issued with byteenable=11.
  - in_last=1: go to DONE; otherwise go to LOW.
- DONE: in_ready=0. Assert done for one cycle, then go to IDLE.
- Write address = base + word_count, modulo DEPTH. Writes past 1023 wrap to 0.
- word_count increments once per issued write.
- Limit: once word_count == effective len_words, no further writes are issued.
  - Further bytes are still accepted (drained), discarded, and set overflow.
  - The frame still ends on in_last.
- busy=1 in LOW, HIGH and DONE.
- start while busy: ignored.
- in_last with in_valid=0: ignored.
- Reset mid-load: next cycle FSM is IDLE and write/chipselect=0. Any partial word is discarded and the RAM is not touched.
- Reset values: in_ready, write, chipselect, busy, done, overflow = 0; address, byteenable, writedata, word_count = 0; clken=1.

## Timing
- All outputs are registered except in_ready, which decodes the FSM state.
- A byte that completes a word, accepted in cycle N, produces write=chipselect=1 with address, byteenable and writedata valid in cycle N+1 only.
- word_count reflects the new value in N+1.
- Back-to-back bytes (one per cycle) never stall: a word completes at most every 2 cycles, so in_ready never drops for back-pressure.
- in_last accepted in cycle N:
  - state=DONE in N+1, together with any final write pulse;
  - done=1 and busy=0 in N+2, IDLE from N+2.
- The earliest accepted start after done is cycle N+2.

## Structure
- Shared package ram_loader_pkg holds:
  - FSM state enum (IDLE/LOW/HIGH/DONE);
  - ADDR_W default and DEPTH;
  - byteenable constants BE_LOW=2'b01, BE_BOTH=2'b11.
- Single module; the packer and FSM share state, so no sub-module is natural.

## Test plan
- base=0x010, len=4, bytes 11 22 33 44 (last on 44) -> writes 0x2211@0x010 and 0x4433@0x011, BE=11; word_count=2; done at N+2; overflow=0.
- base=0x020, len=8, bytes AA BB CC (last on CC) -> 0xBBAA@0x020 BE=11, then 0x00CC@0x021 BE=01; word_count=2.
- base=0x3FF, len=2, 4 bytes 01 02 03 04 -> 0x0201@0x3FF, then 0x0403@0x000 (wrap).
- len=1, bytes 5A A5 C3 D4 (last on D4) -> one write 0xA55A; overflow=1; word_count=1; done still pulses.
- Reset asserted in HIGH after the low byte -> no write; all outputs at reset values next cycle; new start behaves normally.
- start pulsed during a load -> ignored; base/len unchanged; load completes as the first start set up.
